// File: rtl/klp32_pkg.sv
// Shared constants for the KLP32 core.
package klp32_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREGS_RV32I  = 32;
  localparam int NREGS_RV32E  = 16;
  localparam int REG_ZERO     = 0;
endpackage

// File: rtl/regfile_2w2r_sb_if.sv
// Read, writeback and issue bundle of the GPR file.
interface regfile_2w2r_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
);
  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             wb0_en;
  logic [AW-1:0]    wb0_addr;
  logic [XLEN-1:0]  wb0_data;
  logic             wb1_en;
  logic [AW-1:0]    wb1_addr;
  logic [XLEN-1:0]  wb1_data;
  logic             iss_en;
  logic [AW-1:0]    iss_rd;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output rs1_addr, rs2_addr,
    output wb0_en, wb0_addr, wb0_data,
    output wb1_en, wb1_addr, wb1_data,
    output iss_en, iss_rd,
    input  rs1_data, rs2_data,
    input  rs1_busy, rs2_busy, busy_vec
  );

  modport slave (
    input  rs1_addr, rs2_addr,
    input  wb0_en, wb0_addr, wb0_data,
    input  wb1_en, wb1_addr, wb1_data,
    input  iss_en, iss_rd,
    output rs1_data, rs2_data,
    output rs1_busy, rs2_busy, busy_vec
  );
endinterface

// File: rtl/regfile_2w2r_sb_scoreboard.sv
// Pending-write busy bits; a same-cycle issue beats a writeback clear.
module regfile_scoreboard
  import klp32_pkg::*;
#(
  parameter int NREGS = NREGS_RV32I,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  input  logic             wb0_en,
  input  logic [AW-1:0]    wb0_addr,
  input  logic             wb1_en,
  input  logic [AW-1:0]    wb1_addr,
  output logic [NREGS-1:0] busy_vec,
  output logic [NREGS-1:0] wr_vec
);
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] iss_hit;

  always_comb begin
    busy_d  = busy_q;
    wr_vec  = '0;
    iss_hit = '0;
    for (int r = 1; r < NREGS; r++) begin
      wr_vec[r] = (wb0_en && wb0_addr == AW'(r)) ||
                  (wb1_en && wb1_addr == AW'(r));
      iss_hit[r] = iss_en && iss_rd == AW'(r);
      if (iss_hit[r])
        busy_d[r] = 1'b1;
      else if (wr_vec[r])
        busy_d[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_2w2r_sb.sv
// Two-read / two-write GPR file with same-cycle bypass and RAW scoreboard.
module regfile_2w2r_sb
  import klp32_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_RV32I
) (
  input logic clk,
  input logic rst_n,
  regfile_2w2r_sb_if.slave rf
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

  logic [XLEN-1:0]  gpr_q [NREGS];
  logic [XLEN-1:0]  gpr_d [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic [NREGS-1:0] wr_vec;
  logic             w0_ok;
  logic             w1_ok;

  assign w0_ok = rf.wb0_en && rf.wb0_addr != RZ;
  assign w1_ok = rf.wb1_en && rf.wb1_addr != RZ;

  // wb1 is applied last so it wins a same-address collision
  always_comb begin
    for (int i = 0; i < NREGS; i++)
      gpr_d[i] = gpr_q[i];
    if (w0_ok)
      gpr_d[rf.wb0_addr] = rf.wb0_data;
    if (w1_ok)
      gpr_d[rf.wb1_addr] = rf.wb1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        gpr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        gpr_q[i] <= gpr_d[i];
    end
  end

  always_comb begin
    rf.rs1_data = gpr_q[rf.rs1_addr];
    if (rf.rs1_addr == RZ)
      rf.rs1_data = '0;
    else if (w1_ok && rf.wb1_addr == rf.rs1_addr)
      rf.rs1_data = rf.wb1_data;
    else if (w0_ok && rf.wb0_addr == rf.rs1_addr)
      rf.rs1_data = rf.wb0_data;
  end

  always_comb begin
    rf.rs2_data = gpr_q[rf.rs2_addr];
    if (rf.rs2_addr == RZ)
      rf.rs2_data = '0;
    else if (w1_ok && rf.wb1_addr == rf.rs2_addr)
      rf.rs2_data = rf.wb1_data;
    else if (w0_ok && rf.wb0_addr == rf.rs2_addr)
      rf.rs2_data = rf.wb0_data;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (rf.iss_en),
    .iss_rd   (rf.iss_rd),
    .wb0_en   (rf.wb0_en),
    .wb0_addr (rf.wb0_addr),
    .wb1_en   (rf.wb1_en),
    .wb1_addr (rf.wb1_addr),
    .busy_vec (busy_vec),
    .wr_vec   (wr_vec)
  );

  assign rf.busy_vec = busy_vec;
  assign rf.rs1_busy = busy_vec[rf.rs1_addr] & ~wr_vec[rf.rs1_addr];
  assign rf.rs2_busy = busy_vec[rf.rs2_addr] & ~wr_vec[rf.rs2_addr];
endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
- Next-generation general-purpose register file for the KLP32 core, parametrised in data width and register count (32 for RV32I, 16 for RV32E).
- Provides two read ports and two write ports: WB0 for the ALU writeback and WB1 for the load/long-latency writeback.
- Includes an integrated per-register pending-write scoreboard, so decode can detect RAW hazards against in-flight writes.
- Sits between decode/issue and the writeback stage.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; legal values are 16 or 32.
- AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rs1_addr  input  AW  read port 1 address.
- rs2_addr  input  AW  read port 2 address.
- rs1_data  output  XLEN  read port 1 data (combinational).
- rs2_data  output  XLEN  read port 2 data (combinational).
- rs1_busy  output  1  rs1 has a pending write not resolved this cycle.
- rs2_busy  output  1  rs2 has a pending write not resolved this cycle.
- wb0_en  input  1  write port 0 enable (ALU).
- wb0_addr  input  AW  write port 0 address.
- wb0_data  input  XLEN  write port 0 data.
- wb1_en  input  1  write port 1 enable (load).
- wb1_addr  input  AW  write port 1 address.
- wb1_data  input  XLEN  write port 1 data.
- iss_en  input  1  an instruction with a destination register issues this cycle.
- iss_rd  input  AW  destination of the issuing instruction.
- busy_vec  output  NREGS  scoreboard state, for debug and hazard unit.

Behaviour:
- Reset: while rst_n=0 (asynchronous assert, synchronous release), all registers are 0 and all busy bits are 0. Consequently rs*_data=0, rs*_busy=0 and busy_vec=0.
- Register 0: reads always return 0 and busy is always 0. Writes and issues to addr 0 are ignored.
- Write:
  - On posedge clk, gpr[wbN_addr] <= wbN_data when wbN_en=1 and the address is non-zero.
  - If both ports are enabled to the same address, WB1 wins.
- Read is combinational, with same-cycle bypass:
  - If wb1_en and wb1_addr==rsX_addr!=0, return wb1_data.
  - Else if wb0_en and wb0_addr==rsX_addr!=0, return wb0_data.
  - Else return gpr[rsX_addr].
  - Read latency: 0 cycles. Write-to-array latency: 1 cycle.
- Scoreboard, per register r!=0, next-state rules in priority order:
  1. If iss_en and iss_rd==r, then busy[r] <= 1. A set beats a same-cycle clear, because the new producer supersedes the old one.
  2. Else if (wb0_en and wb0_addr==r) or (wb1_en and wb1_addr==r), then busy[r] <= 0.
  3. Else hold.
- Busy outputs: rsX_busy = busy[rsX_addr] AND NOT (a write to rsX_addr this cycle), so a bypassed write is reported as not busy.
- Issuing to an already-busy register keeps it busy; WAW ordering is the issue stage's responsibility.
- Writes to a non-busy register are legal and simply update data.
- Out-of-range addresses (NREGS=16 with addr[4]=1 cannot occur since AW=4) need no handling.
- Reset mid-operation: all state clears immediately, and pending busy bits are lost by design. The pipeline is flushed on reset.

Decomposition:
- Shared package klp32_pkg:
  - XLEN_DEFAULT=32
  - NREGS_RV32I=32
  - NREGS_RV32E=16
  - REG_ZERO=0
- One sub-module, regfile_scoreboard (params NREGS, AW):
  - Holds the busy bits and the set/clear priority logic.
  - Exports busy_vec and a per-register "written this cycle" vector.
- The top level holds the data array, write arbitration and bypass muxes.

Test Plan:
- Reset: hold rst_n=0, then read rs1=5, rs2=31 → data 0, busy 0, busy_vec=0. Assert rst_n=0 asynchronously mid-cycle after writes → outputs return to 0 immediately.
- Basic write/read: wb0 writes x3=0xDEADBEEF. The next cycle rs1=3 → 0xDEADBEEF. A write of 0x1234 to x0 → rs2=0 reads 0.
- Bypass and dual-write conflict: same cycle wb0 (x7=0x11) and wb1 (x7=0x22) with rs1=7 → rs1_data=0x22 that cycle, and gpr[7]=0x22 afterwards.
- Scoreboard lifecycle:
  - iss x9 → the next cycle rs1=9 gives busy=1.
  - wb1 x9=0xAB in a later cycle → rs1_busy=0 and rs1_data=0xAB in the same cycle, and busy_vec[9]=0 afterwards.
- Simultaneous issue and clear on x4 → busy_vec[4]=1. Issue to x0 → busy_vec[0] stays 0.
- RV32E configuration: NREGS=16, AW=4 → write/read x15=0xFFFF_FFFF, then verify busy_vec width is 16 and reset clears all registers.
